cavlc_enc_ctrl: RTL

CAVLC_ENC_CTRL -- requirements
Module: cavlc_enc_ctrl

---
 rtl/cavlc_enc_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cavlc_enc_ctrl.sv
// CAVLC encoder control: sequences coeff_token, level and zero codewords of
// each coefficient block into a packed 32-bit big-endian output word stream.
// Optional feature macro: CAVLC_ENC_STUFFING_EN (flush appends a '1' stop bit
// and always emits a word); when undefined the flush pads with zeros only.
module cavlc_enc_ctrl (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        Enable,
  input  logic        BlockReady,
  input  logic [15:0] CoeffTokenCode,
  input  logic [4:0]  CoeffTokenLen,
  input  logic [15:0] LevelCode,
  input  logic [4:0]  LevelLen,
  input  logic        LevelValid,
  input  logic        LevelDone,
  input  logic [15:0] ZeroCode,
  input  logic [4:0]  ZeroLen,
  input  logic        ZeroValid,
  input  logic        ZeroDone,
  input  logic        WordReady,
  output logic        CodeAccept,
  output logic        CoeffTokenEncodeEnable,
  output logic        LevelEncodeEnable,
  output logic        ZeroEncodeEnable,
  output logic [31:0] Word,
  output logic        WordValid,
  output logic        BlockDone,
  output logic        Busy
);

  typedef enum logic [2:0] {
    WAIT_ENABLE  = 3'd0,
    COEFF_TOKEN  = 3'd1,
    LEVEL_ENCODE = 3'd2,
    ZERO_ENCODE  = 3'd3,
    FLUSH        = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [31:0] acc, acc_next;
  logic [4:0]  cnt, cnt_next;
  logic [31:0] word_next;
  logic        word_load;
  logic        block_done_next;
  logic        append;

  logic [15:0] sel_code;
  logic [4:0]  sel_len;
  logic [4:0]  eff_len;
  logic [4:0]  shamt;
  logic [15:0] cw_left;
  logic [63:0] merged;
  logic [5:0]  total;
  logic        completes;
  logic        word_free;
  logic        stall;

  // Pick the codeword offered in the current state and merge it behind the pending bits
  always_comb begin
    sel_code = '0;
    sel_len  = '0;
    case (state)
      COEFF_TOKEN: begin
        sel_code = CoeffTokenCode;
        sel_len  = CoeffTokenLen;
      end
      LEVEL_ENCODE: begin
        if (LevelValid) begin
          sel_code = LevelCode;
          sel_len  = LevelLen;
        end
      end
      ZERO_ENCODE: begin
        if (ZeroValid) begin
          sel_code = ZeroCode;
          sel_len  = ZeroLen;
        end
      end
      default: begin
        sel_code = '0;
        sel_len  = '0;
      end
    endcase
    eff_len   = (sel_len > 5'd16) ? 5'd16 : sel_len;
    shamt     = 5'd16 - eff_len;
    cw_left   = sel_code << shamt;
    merged    = {acc, 32'h0} | ({cw_left, 48'h0} >> cnt);
    total     = {1'b0, cnt} + {1'b0, eff_len};
    completes = total[5];
    word_free = !WordValid || WordReady;
    stall     = completes && !word_free;
  end

  // Next-state, accept handshake, accumulator update and word loading
  always_comb begin
    state_next      = state;
    acc_next        = acc;
    cnt_next        = cnt;
    word_next       = Word;
    word_load       = 1'b0;
    block_done_next = 1'b0;
    CodeAccept      = 1'b0;
    append          = 1'b0;
    case (state)
      WAIT_ENABLE: begin
        if (Enable && BlockReady) state_next = COEFF_TOKEN;
      end
      COEFF_TOKEN: begin
        CodeAccept = !stall;
        if (!stall) begin
          append     = 1'b1;
          state_next = LEVEL_ENCODE;
        end
      end
      LEVEL_ENCODE: begin
        CodeAccept = !stall;
        if (!stall) begin
          append = LevelValid;
          if (LevelDone) state_next = ZERO_ENCODE;
        end
      end
      ZERO_ENCODE: begin
        CodeAccept = !stall;
        if (!stall) begin
          append = ZeroValid;
          if (ZeroDone) begin
            block_done_next = 1'b1;
            if (Enable && BlockReady) state_next = COEFF_TOKEN;
            else if (!Enable)         state_next = FLUSH;
            else                      state_next = WAIT_ENABLE;
          end
        end
      end
      FLUSH: begin
`ifdef CAVLC_ENC_STUFFING_EN
        if (word_free) begin
          word_load  = 1'b1;
          word_next  = acc | (32'h8000_0000 >> cnt);
          acc_next   = '0;
          cnt_next   = '0;
          state_next = WAIT_ENABLE;
        end
`else
        if (cnt == 5'd0) begin
          state_next = WAIT_ENABLE;
        end else if (word_free) begin
          word_load  = 1'b1;
          word_next  = acc;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = WAIT_ENABLE;
        end
`endif
      end
      default: begin
        state_next = WAIT_ENABLE;
      end
    endcase
    if (append) begin
      cnt_next = total[4:0];
      if (completes) begin
        word_load = 1'b1;
        word_next = merged[63:32];
        acc_next  = merged[31:0];
      end else begin
        acc_next  = merged[63:32];
      end
    end
  end

  // State, accumulator and output word registers
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state                  <= WAIT_ENABLE;
      acc                    <= '0;
      cnt                    <= '0;
      Word                   <= '0;
      WordValid              <= 1'b0;
      BlockDone              <= 1'b0;
      CoeffTokenEncodeEnable <= 1'b0;
      LevelEncodeEnable      <= 1'b0;
      ZeroEncodeEnable       <= 1'b0;
    end else begin
      state                  <= state_next;
      acc                    <= acc_next;
      cnt                    <= cnt_next;
      BlockDone              <= block_done_next;
      CoeffTokenEncodeEnable <= (state == COEFF_TOKEN);
      LevelEncodeEnable      <= (state == LEVEL_ENCODE);
      ZeroEncodeEnable       <= (state == ZERO_ENCODE);
      if (word_load) begin
        Word      <= word_next;
        WordValid <= 1'b1;
      end else if (WordReady) begin
        WordValid <= 1'b0;
      end
    end
  end

  // Busy covers both an active block and an undelivered output word
  always_comb begin
    Busy = (state != WAIT_ENABLE) || WordValid;
  end

endmodule
